// File: rtl/wishbone_data_bridge_pkg.sv
// Shared definitions for the data-side Wishbone bridge: FSM encodings, stall levels
// and the select-bus width.
package wishbone_data_bridge_pkg;

  typedef enum logic [1:0] {
    BusIdle         = 2'b00,
    BusBusy         = 2'b01,
    BusWaitForStall = 2'b10
  } bus_state_e;

  localparam logic StopYes = 1'b1;
  localparam logic StopNo  = 1'b0;

  localparam int unsigned WishboneSelBus = 4;
  typedef logic [WishboneSelBus-1:0] wishbone_sel_t;

endpackage

// File: rtl/wishbone_data_bridge.sv
// Converts the core's single-cycle data-RAM request into a Wishbone B4 classic cycle,
// stalling the pipeline until ack. Optional bus timeout via WB_TIMEOUT_EN.
module wishbone_data_bridge
  import wishbone_data_bridge_pkg::*;
#(
  parameter int unsigned STALL_WIDTH    = 6,
  parameter int unsigned STALL_INDEX    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STALL_WIDTH-1:0] stop_all,
  input  logic                   flush,
  input  logic                   cpu_chip_enable,
  input  logic [31:0]            cpu_address,
  input  logic [31:0]            cpu_data_input,
  input  logic                   cpu_write_enable,
  input  wishbone_sel_t          cpu_sel,
  output logic [31:0]            cpu_data_output,
  output logic                   stop_all_req_from_bus,
  output logic                   bus_error,
  input  logic [31:0]            wishbone_data_input,
  input  logic                   wishbone_ack_input,
  output logic [31:0]            wishbone_address_output,
  output logic [31:0]            wishbone_data_output,
  output logic                   wishbone_write_enable_output,
  output wishbone_sel_t          wishbone_sel_output,
  output logic                   wishbone_strobe_output,
  output logic                   wishbone_cycle_output
);

  bus_state_e    state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  wishbone_sel_t sel_q, sel_d;
  logic          stb_q, stb_d;
  logic          cyc_q, cyc_d;
  logic [31:0]   rd_buf_q, rd_buf_d;
  logic          err_q, err_d;

  // Only the memory-stage bit of the stall vector matters here.
  logic unused_stop_all;
  assign unused_stop_all = ^stop_all;

  logic mem_stalled;
  assign mem_stalled = (stop_all[STALL_INDEX] == StopYes);

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CntW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= BusIdle;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
      rd_buf_q <= '0;
      err_q    <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      stb_q    <= stb_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
      err_q    <= err_d;
`ifdef WB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    sel_d    = sel_q;
    stb_d    = stb_q;
    cyc_d    = cyc_q;
    rd_buf_d = rd_buf_q;
    err_d    = 1'b0;
`ifdef WB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    unique case (state_q)
      BusIdle: begin
        if (cpu_chip_enable && !flush) begin
          adr_d    = cpu_address;
          dat_d    = cpu_data_input;
          we_d     = cpu_write_enable;
          sel_d    = cpu_sel;
          stb_d    = 1'b1;
          cyc_d    = 1'b1;
          rd_buf_d = '0;
          state_d  = BusBusy;
`ifdef WB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end

      BusBusy: begin
        if (flush || wishbone_ack_input) begin
          adr_d = '0;
          dat_d = '0;
          we_d  = 1'b0;
          sel_d = '0;
          stb_d = 1'b0;
          cyc_d = 1'b0;
        end
        // Flush wins over a simultaneous ack.
        if (flush) begin
          rd_buf_d = '0;
          state_d  = BusIdle;
        end else if (wishbone_ack_input) begin
          if (!we_q) rd_buf_d = wishbone_data_input;
          state_d = mem_stalled ? BusWaitForStall : BusIdle;
        end else begin
`ifdef WB_TIMEOUT_EN
          if (timeout_hit) begin
            adr_d    = '0;
            dat_d    = '0;
            we_d     = 1'b0;
            sel_d    = '0;
            stb_d    = 1'b0;
            cyc_d    = 1'b0;
            rd_buf_d = '0;
            err_d    = 1'b1;
            state_d  = BusIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end

      BusWaitForStall: begin
        if (!mem_stalled) state_d = BusIdle;
      end

      default: state_d = BusIdle;
    endcase
  end

  always_comb begin
    stop_all_req_from_bus = StopNo;
    if (state_q == BusIdle && cpu_chip_enable && !flush) begin
      stop_all_req_from_bus = StopYes;
    end else if (state_q == BusBusy && !wishbone_ack_input && !flush) begin
      stop_all_req_from_bus = StopYes;
    end
  end

  // Load data bypasses the buffer in the ack cycle so the stage sees it without delay.
  assign cpu_data_output = (state_q == BusBusy && wishbone_ack_input && !we_q) ?
                           wishbone_data_input : rd_buf_q;

  assign wishbone_address_output      = adr_q;
  assign wishbone_data_output         = dat_q;
  assign wishbone_write_enable_output = we_q;
  assign wishbone_sel_output          = sel_q;
  assign wishbone_strobe_output       = stb_q;
  assign wishbone_cycle_output        = cyc_q;
  assign bus_error                    = err_q;

endmodule

// File: tb/tb_wishbone_data_bridge.sv
// Directed self-checking bench for wishbone_data_bridge; the timeout scenario runs
// only when WB_TIMEOUT_EN is defined.
module tb_wishbone_data_bridge;

  logic        clock;
  logic        reset;
  logic [5:0]  stop_all;
  logic        flush;
  logic        cpu_chip_enable;
  logic [31:0] cpu_address;
  logic [31:0] cpu_data_input;
  logic        cpu_write_enable;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_data_output;
  logic        stop_all_req_from_bus;
  logic        bus_error;
  logic [31:0] wishbone_data_input;
  logic        wishbone_ack_input;
  logic [31:0] wishbone_address_output;
  logic [31:0] wishbone_data_output;
  logic        wishbone_write_enable_output;
  logic [3:0]  wishbone_sel_output;
  logic        wishbone_strobe_output;
  logic        wishbone_cycle_output;

  int checks = 0;
  int errors = 0;

  wishbone_data_bridge #(
    .STALL_WIDTH   (6),
    .STALL_INDEX   (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock                       (clock),
    .reset                       (reset),
    .stop_all                    (stop_all),
    .flush                       (flush),
    .cpu_chip_enable             (cpu_chip_enable),
    .cpu_address                 (cpu_address),
    .cpu_data_input              (cpu_data_input),
    .cpu_write_enable            (cpu_write_enable),
    .cpu_sel                     (cpu_sel),
    .cpu_data_output             (cpu_data_output),
    .stop_all_req_from_bus       (stop_all_req_from_bus),
    .bus_error                   (bus_error),
    .wishbone_data_input         (wishbone_data_input),
    .wishbone_ack_input          (wishbone_ack_input),
    .wishbone_address_output     (wishbone_address_output),
    .wishbone_data_output        (wishbone_data_output),
    .wishbone_write_enable_output(wishbone_write_enable_output),
    .wishbone_sel_output         (wishbone_sel_output),
    .wishbone_strobe_output      (wishbone_strobe_output),
    .wishbone_cycle_output       (wishbone_cycle_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 1ns later.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic request(input logic [31:0] addr, input logic [31:0] data,
                         input logic we, input logic [3:0] sel);
    cpu_chip_enable  = 1'b1;
    cpu_address      = addr;
    cpu_data_input   = data;
    cpu_write_enable = we;
    cpu_sel          = sel;
  endtask

  initial begin
    reset = 1'b1;
    stop_all = '0;
    flush = 1'b0;
    cpu_chip_enable = 1'b0;
    cpu_address = '0;
    cpu_data_input = '0;
    cpu_write_enable = 1'b0;
    cpu_sel = '0;
    wishbone_data_input = '0;
    wishbone_ack_input = 1'b0;

    tick();
    tick();
    settle();
    check("rst_cyc", 32'(wishbone_cycle_output), 32'd0);
    check("rst_stb", 32'(wishbone_strobe_output), 32'd0);
    check("rst_adr", wishbone_address_output, 32'd0);
    check("rst_rdata", cpu_data_output, 32'd0);
    check("rst_stall", 32'(stop_all_req_from_bus), 32'd0);
    check("rst_err", 32'(bus_error), 32'd0);
    reset = 1'b0;

    // Zero-wait load
    tick();
    request(32'h0000_0010, 32'h0, 1'b0, 4'hF);
    settle();
    check("ld_req_stall", 32'(stop_all_req_from_bus), 32'd1);
    check("ld_req_cyc", 32'(wishbone_cycle_output), 32'd0);
    tick();
    cpu_chip_enable = 1'b0;
    wishbone_ack_input = 1'b1;
    wishbone_data_input = 32'hDEAD_BEEF;
    settle();
    check("ld_cyc", 32'(wishbone_cycle_output), 32'd1);
    check("ld_adr", wishbone_address_output, 32'h0000_0010);
    check("ld_sel", 32'(wishbone_sel_output), 32'hF);
    check("ld_ack_stall", 32'(stop_all_req_from_bus), 32'd0);
    check("ld_bypass", cpu_data_output, 32'hDEAD_BEEF);
    tick();
    wishbone_ack_input = 1'b0;
    wishbone_data_input = 32'h0;
    settle();
    check("ld_after_cyc", 32'(wishbone_cycle_output), 32'd0);
    check("ld_after_stb", 32'(wishbone_strobe_output), 32'd0);
    check("ld_after_adr", wishbone_address_output, 32'd0);
    check("ld_held", cpu_data_output, 32'hDEAD_BEEF);

    // Store with 3 wait states
    request(32'h0000_0020, 32'h1234_5678, 1'b1, 4'b0011);
    settle();
    check("st_req_stall", 32'(stop_all_req_from_bus), 32'd1);
    tick();
    cpu_chip_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("st_wait_cyc", 32'(wishbone_cycle_output), 32'd1);
      check("st_wait_we", 32'(wishbone_write_enable_output), 32'd1);
      check("st_wait_sel", 32'(wishbone_sel_output), 32'b0011);
      check("st_wait_dat", wishbone_data_output, 32'h1234_5678);
      check("st_wait_adr", wishbone_address_output, 32'h0000_0020);
      check("st_wait_stall", 32'(stop_all_req_from_bus), 32'd1);
      tick();
    end
    wishbone_ack_input = 1'b1;
    wishbone_data_input = 32'h5555_AAAA;
    settle();
    check("st_ack_dat", wishbone_data_output, 32'h1234_5678);
    check("st_ack_stall", 32'(stop_all_req_from_bus), 32'd0);
    check("st_no_bypass", cpu_data_output, 32'd0);
    tick();
    wishbone_ack_input = 1'b0;
    wishbone_data_input = 32'h0;
    settle();
    check("st_after_cyc", 32'(wishbone_cycle_output), 32'd0);
    check("st_after_we", 32'(wishbone_write_enable_output), 32'd0);
    check("st_after_sel", 32'(wishbone_sel_output), 32'd0);
    check("st_after_rdata", cpu_data_output, 32'd0);

    // Load acked under an external memory-stage stall
    request(32'h0000_0030, 32'h0, 1'b0, 4'hF);
    tick();
    cpu_chip_enable = 1'b0;
    wishbone_ack_input = 1'b1;
    wishbone_data_input = 32'hCAFE_F00D;
    stop_all = 6'b010000;
    settle();
    check("xs_bypass", cpu_data_output, 32'hCAFE_F00D);
    tick();
    wishbone_ack_input = 1'b0;
    wishbone_data_input = 32'h0;
    for (int i = 0; i < 3; i++) begin
      request(32'h0000_0099, 32'h0, 1'b0, 4'hF);
      settle();
      check("xs_wait_stall", 32'(stop_all_req_from_bus), 32'd0);
      check("xs_wait_cyc", 32'(wishbone_cycle_output), 32'd0);
      check("xs_wait_rdata", cpu_data_output, 32'hCAFE_F00D);
      tick();
    end
    cpu_chip_enable = 1'b0;
    stop_all = '0;
    settle();
    check("xs_release_cyc", 32'(wishbone_cycle_output), 32'd0);
    tick();

    // Back in idle: new load, then flush with a simultaneous ack
    request(32'h0000_0040, 32'h0, 1'b0, 4'hF);
    settle();
    check("fl_idle_stall", 32'(stop_all_req_from_bus), 32'd1);
    tick();
    cpu_chip_enable = 1'b0;
    settle();
    check("fl_busy1_cyc", 32'(wishbone_cycle_output), 32'd1);
    check("fl_busy1_adr", wishbone_address_output, 32'h0000_0040);
    tick();
    flush = 1'b1;
    wishbone_ack_input = 1'b1;
    wishbone_data_input = 32'h1111_2222;
    settle();
    check("fl_stall", 32'(stop_all_req_from_bus), 32'd0);
    tick();
    flush = 1'b0;
    wishbone_ack_input = 1'b0;
    wishbone_data_input = 32'h0;
    settle();
    check("fl_cyc", 32'(wishbone_cycle_output), 32'd0);
    check("fl_stb", 32'(wishbone_strobe_output), 32'd0);
    check("fl_buf", cpu_data_output, 32'd0);
    check("fl_after_stall", 32'(stop_all_req_from_bus), 32'd0);

    // Reset in the middle of a store, then a stray ack
    request(32'h0000_0050, 32'h0000_A5A5, 1'b1, 4'hC);
    tick();
    cpu_chip_enable = 1'b0;
    settle();
    check("rs_busy_cyc", 32'(wishbone_cycle_output), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rs_cyc", 32'(wishbone_cycle_output), 32'd0);
    check("rs_adr", wishbone_address_output, 32'd0);
    check("rs_dat", wishbone_data_output, 32'd0);
    check("rs_we", 32'(wishbone_write_enable_output), 32'd0);
    wishbone_ack_input = 1'b1;
    wishbone_data_input = 32'hFFFF_0000;
    settle();
    check("rs_late_ack_rdata", cpu_data_output, 32'd0);
    check("rs_late_ack_stall", 32'(stop_all_req_from_bus), 32'd0);
    tick();
    wishbone_ack_input = 1'b0;
    wishbone_data_input = 32'h0;
    settle();
    check("rs_late_ack_cyc", 32'(wishbone_cycle_output), 32'd0);
    check("rs_late_ack_buf", cpu_data_output, 32'd0);
    check("rs_err", 32'(bus_error), 32'd0);

`ifdef WB_TIMEOUT_EN
    // Unacknowledged load aborts after four busy cycles
    request(32'h0000_0060, 32'h0, 1'b0, 4'hF);
    tick();
    cpu_chip_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("to_busy_cyc", 32'(wishbone_cycle_output), 32'd1);
      check("to_busy_err", 32'(bus_error), 32'd0);
      check("to_busy_stall", 32'(stop_all_req_from_bus), 32'd1);
      tick();
    end
    settle();
    check("to_cyc", 32'(wishbone_cycle_output), 32'd0);
    check("to_err", 32'(bus_error), 32'd1);
    check("to_stall", 32'(stop_all_req_from_bus), 32'd0);
    check("to_rdata", cpu_data_output, 32'd0);
    tick();
    settle();
    check("to_err_pulse", 32'(bus_error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wishbone_data_bridge.md
Name: wishbone_data_bridge

Overview:
- Sits directly downstream of the core's data-RAM port.
- Converts the core's single-cycle RAM request (chip enable, address, data, write enable, byte select) into a Wishbone B4 classic master cycle.
- Raises a stall request to the pipeline controller until the slave acknowledges.
- Holds read data stable while the pipeline remains stalled for other reasons, so slow external memories and peripherals can replace the zero-wait RAM.

Parameters:
- STALL_WIDTH, 6, width of the pipeline stall vector from ctrl.
- STALL_INDEX, 4, bit of the stall vector that freezes the consuming (memory) stage.
- TIMEOUT_CYCLES, 255, BUSY cycles before abort (only with WB_TIMEOUT_EN).

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high
- stop_all  input  STALL_WIDTH  pipeline stall vector from ctrl
- flush  input  1  abort any pending/outstanding access
- cpu_chip_enable  input  1  access request from memory stage
- cpu_address  input  32  byte address
- cpu_data_input  input  32  store data
- cpu_write_enable  input  1  1=store, 0=load
- cpu_sel  input  4  byte lanes
- cpu_data_output  output  32  load data to memory stage
- stop_all_req_from_bus  output  1  stall request to ctrl
- bus_error  output  1  one-cycle pulse on timeout (WB_TIMEOUT_EN only; tied 0 otherwise)
- wishbone_data_input  input  32  slave read data
- wishbone_ack_input  input  1  slave acknowledge
- wishbone_address_output  output  32  adr_o
- wishbone_data_output  output  32  dat_o
- wishbone_write_enable_output  output  1  we_o
- wishbone_sel_output  output  4  sel_o
- wishbone_strobe_output  output  1  stb_o
- wishbone_cycle_output  output  1  cyc_o

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On reset:
  - state=IDLE
  - all wishbone outputs 0
  - read buffer 0
  - cpu_data_output 0
  - stop_all_req_from_bus 0
  - bus_error 0
- States: IDLE, BUSY, WAIT_FOR_STALL.
- IDLE:
  - If cpu_chip_enable=1 and flush=0: register address/data/we/sel onto the bus, assert stb=cyc=1, clear read buffer, go BUSY.
  - Otherwise stay IDLE.
- BUSY:
  - Bus outputs are held constant until ack.
  - On wishbone_ack_input=1: deassert stb, cyc, we, sel, address and data (all to 0). If we=0, latch wishbone_data_input into the read buffer.
  - After ack: go WAIT_FOR_STALL if stop_all[STALL_INDEX]=1, else go IDLE.
  - flush=1 in BUSY (with or without ack): drop the cycle (all bus outputs 0), clear the buffer, go IDLE. Flush takes priority over ack.
- WAIT_FOR_STALL: when stop_all[STALL_INDEX]=0, go IDLE. Bus idle throughout.
- stop_all_req_from_bus (combinational):
  - 1 in IDLE when cpu_chip_enable=1 and flush=0.
  - 1 in BUSY while ack=0 and flush=0.
  - 0 otherwise.
- cpu_data_output (combinational):
  - In BUSY with ack=1 and we=0: wishbone_data_input (bypass).
  - Otherwise: the read buffer.
- Latency: minimum access is 2 cycles (request cycle + ack cycle). Stall is asserted from the request cycle through the cycle before ack.
- An ack seen in IDLE or WAIT_FOR_STALL is ignored.
- Back-to-back requests: a new request is accepted only from IDLE, so at least one idle bus cycle separates accesses.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- With the macro defined:
  - An 8+-bit counter clears on entry to BUSY and increments on each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: drop the cycle, set the read buffer to 0, pulse bus_error for one cycle, release the stall, go IDLE.
- Without the macro: no counter; BUSY waits indefinitely; bus_error is tied 0.

Decomposition:
- Add to the shared defines header: state encodings (BusIdle=2'b00, BusBusy=2'b01, BusWaitForStall=2'b10), StopYes/StopNo, and WishboneSelBus 3:0.
- No sub-module is needed; the FSM, buffer and optional counter sit in one module.

Test Plan:
- Load, zero-wait: ce=1, we=0, addr=0x0000_0010; ack asserted the cycle after stb with dat=0xDEAD_BEEF → stall high for 1 cycle; cpu_data_output=0xDEAD_BEEF in the ack cycle and held afterwards; stb/cyc low the cycle after ack.
- Store, 3 wait states: ce=1, we=1, sel=4'b0011, data=0x1234_5678; ack after 3 cycles → bus outputs stable for all 4 BUSY cycles; stall high 4 cycles; return to IDLE.
- External stall: load acked while stop_all[4]=1 held 3 more cycles → state WAIT_FOR_STALL; no new cycle starts; cpu_data_output stable; IDLE once stop_all[4]=0.
- Flush mid-access: flush=1 in the 2nd BUSY cycle, with ack arriving simultaneously → cyc/stb drop; buffer=0; stall released; IDLE.
- Reset mid-access: reset=1 in BUSY → next edge all outputs 0, state IDLE; a late ack afterwards is ignored.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack → bus_error pulses once after 4 BUSY cycles; cpu_data_output=0; stall released.
